// File: rtl/picnic_pkg.sv
// rtl/picnic_pkg.sv - shared constants and proof field state type for the round proof packer
package picnic_pkg;

   localparam int W          = 32;
   localparam int N_PARTY    = 16;
   localparam int SEED_WORDS = 60;
   localparam int COM_WORDS  = 8;
   localparam int AUX_WORDS  = 32;
   localparam int KEY_WORDS  = 4;
   localparam int MSG_WORDS  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_COM,
      ST_AUX,
      ST_KEY,
      ST_MSG,
      ST_DONE
   } proof_field_t;

endpackage

// File: rtl/round_proof_packer_if.sv
// rtl/round_proof_packer_if.sv - 32-bit word stream from the round proof packer
interface round_proof_packer_if;

   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        dout_last;

   modport master (output dout, output dout_valid, output dout_last, input dout_ready);
   modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);

endinterface

// File: rtl/round_proof_word_mux.sv
// rtl/round_proof_word_mux.sv - selects the 32-bit proof word addressed by field, party and word counters
module round_proof_word_mux
   import picnic_pkg::*;
(
   input  proof_field_t   state,
   input  logic [3:0]     party_cnt,
   input  logic [5:0]     word_cnt,
   input  logic [3:0]     p,
   input  logic [2047:0]  seeds,
   input  logic [4095:0]  C,
   input  logic [1023:0]  aux_triangle,
   input  logic [127:0]   masked_key,
   input  logic [511:0]   msgs,
   output logic [W-1:0]   word
);

   logic [10:0] woff;
   logic [10:0] seed_idx;
   logic [11:0] com_idx;

   // Bit offsets: 128 bits per seed, 256 bits per commitment, 32 bits per word.
   assign woff     = {word_cnt, 5'b0};
   assign seed_idx = {party_cnt, 7'b0} + woff;
   assign com_idx  = {p, 8'b0} + {1'b0, woff};

   always_comb begin
      word = '0;
      case (state)
         ST_SEED: word = seeds[seed_idx +: W];
         ST_COM:  word = C[com_idx +: W];
         ST_AUX:  word = aux_triangle[woff[9:0] +: W];
         ST_KEY:  word = masked_key[woff[6:0] +: W];
         ST_MSG:  word = msgs[woff[8:0] +: W];
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/round_proof_packer.sv
// rtl/round_proof_packer.sv - streams the opened material of one parallel repetition as 32-bit words
module round_proof_packer
   import picnic_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           t_in_LC,
   input  logic [3:0]     p,
   input  logic [2047:0]  seeds,
   input  logic [4095:0]  C,
   input  logic [1023:0]  aux_triangle,
   input  logic [127:0]   masked_key,
   input  logic [511:0]   msgs,
   round_proof_packer_if.master out_if,
   output logic           busy,
   output logic           done
);

   proof_field_t state, nxt_state;
   logic [3:0]   party_cnt, nxt_party;
   logic [5:0]   word_cnt, nxt_word;
   logic [3:0]   p_reg, p_eff;
   logic [3:0]   party_inc, party_skip;
   logic         seed_last;
   logic [W-1:0] dout_r, mux_word;
   logic         valid_r, last_r, nxt_valid, nxt_last, load;
   logic         hs;

   assign hs         = valid_r && out_if.dout_ready;
   assign p_eff      = (state == ST_IDLE) ? p : p_reg;
   assign party_inc  = party_cnt + 4'd1;
   assign party_skip = (party_inc == p_reg) ? party_cnt + 4'd2 : party_inc;
   assign seed_last  = (party_cnt == 4'd15) || (party_cnt == 4'd14 && p_reg == 4'd15);

   // The mux looks at the position being moved to, so dout is loaded in the same edge.
   round_proof_word_mux u_mux (
      .state        (nxt_state),
      .party_cnt    (nxt_party),
      .word_cnt     (nxt_word),
      .p            (p_eff),
      .seeds        (seeds),
      .C            (C),
      .aux_triangle (aux_triangle),
      .masked_key   (masked_key),
      .msgs         (msgs),
      .word         (mux_word)
   );

   always_comb begin
      nxt_state = state;
      nxt_party = party_cnt;
      nxt_word  = word_cnt;
      nxt_valid = valid_r;
      nxt_last  = last_r;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (t_in_LC) begin
                  nxt_state = ST_SEED;
                  nxt_party = (p == 4'd0) ? 4'd1 : 4'd0;
                  nxt_word  = '0;
                  nxt_valid = 1'b1;
                  load      = 1'b1;
               end else begin
                  nxt_state = ST_DONE;
               end
            end
         end
         ST_SEED: begin
            if (hs) begin
               load     = 1'b1;
               nxt_word = '0;
               if (word_cnt != 6'd3) begin
                  nxt_word = word_cnt + 6'd1;
               end else if (seed_last) begin
                  nxt_state = ST_COM;
                  nxt_party = '0;
               end else begin
                  nxt_party = party_skip;
               end
            end
         end
         ST_COM: begin
            if (hs) begin
               load     = 1'b1;
               nxt_word = word_cnt + 6'd1;
               if (word_cnt == 6'(COM_WORDS - 1)) begin
                  nxt_state = (p_reg == 4'd15) ? ST_KEY : ST_AUX;
                  nxt_word  = '0;
               end
            end
         end
         ST_AUX: begin
            if (hs) begin
               load     = 1'b1;
               nxt_word = word_cnt + 6'd1;
               if (word_cnt == 6'(AUX_WORDS - 1)) begin
                  nxt_state = ST_KEY;
                  nxt_word  = '0;
               end
            end
         end
         ST_KEY: begin
            if (hs) begin
               load     = 1'b1;
               nxt_word = word_cnt + 6'd1;
               if (word_cnt == 6'(KEY_WORDS - 1)) begin
                  nxt_state = ST_MSG;
                  nxt_word  = '0;
               end
            end
         end
         ST_MSG: begin
            if (hs) begin
               if (word_cnt == 6'(MSG_WORDS - 1)) begin
                  nxt_state = ST_DONE;
                  nxt_word  = '0;
                  nxt_valid = 1'b0;
                  nxt_last  = 1'b0;
               end else begin
                  load     = 1'b1;
                  nxt_word = word_cnt + 6'd1;
                  nxt_last = (word_cnt == 6'(MSG_WORDS - 2));
               end
            end
         end
         ST_DONE: begin
            nxt_state = ST_IDLE;
            nxt_party = '0;
            nxt_word  = '0;
         end
         default: begin
            nxt_state = ST_IDLE;
            nxt_valid = 1'b0;
            nxt_last  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         party_cnt <= '0;
         word_cnt  <= '0;
         p_reg     <= '0;
         dout_r    <= '0;
         valid_r   <= 1'b0;
         last_r    <= 1'b0;
      end else begin
         state     <= nxt_state;
         party_cnt <= nxt_party;
         word_cnt  <= nxt_word;
         valid_r   <= nxt_valid;
         last_r    <= nxt_last;
         if (state == ST_IDLE && start) begin
            p_reg <= p;
         end
         if (load) begin
            dout_r <= mux_word;
         end
      end
   end

   assign out_if.dout       = dout_r;
   assign out_if.dout_valid = valid_r;
   assign out_if.dout_last  = last_r;
   assign busy              = (state != ST_IDLE);
   assign done              = (state == ST_DONE);

endmodule

// File: tb/tb_round_proof_packer.sv
// tb/tb_round_proof_packer.sv - scoreboard bench for the round proof packer
module tb_round_proof_packer;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           t_in_LC;
   logic [3:0]     p;
   logic [2047:0]  seeds;
   logic [4095:0]  C;
   logic [1023:0]  aux_triangle;
   logic [127:0]   masked_key;
   logic [511:0]   msgs;
   logic           busy;
   logic           done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [31:0] ref_q[$];

   round_proof_packer_if sif ();

   round_proof_packer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .t_in_LC      (t_in_LC),
      .p            (p),
      .seeds        (seeds),
      .C            (C),
      .aux_triangle (aux_triangle),
      .masked_key   (masked_key),
      .msgs         (msgs),
      .out_if       (sif),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic fill_random();
      for (int i = 0; i < 64; i++)  seeds[i*32 +: 32] = $urandom();
      for (int i = 0; i < 128; i++) C[i*32 +: 32] = $urandom();
      for (int i = 0; i < 32; i++)  aux_triangle[i*32 +: 32] = $urandom();
      for (int i = 0; i < 4; i++)   masked_key[i*32 +: 32] = $urandom();
      for (int i = 0; i < 16; i++)  msgs[i*32 +: 32] = $urandom();
   endtask

   task automatic push_expected(input int pp);
      exp_q.delete();
      for (int k = 0; k < 16; k++)
         if (k != pp)
            for (int w = 0; w < 4; w++) exp_q.push_back(seeds[k*128 + w*32 +: 32]);
      for (int w = 0; w < 8; w++) exp_q.push_back(C[pp*256 + w*32 +: 32]);
      if (pp != 15)
         for (int w = 0; w < 32; w++) exp_q.push_back(aux_triangle[w*32 +: 32]);
      for (int w = 0; w < 4; w++)  exp_q.push_back(masked_key[w*32 +: 32]);
      for (int w = 0; w < 16; w++) exp_q.push_back(msgs[w*32 +: 32]);
   endtask

   // Drives one round and collects every handshaken word into got_q.
   task automatic drive_round(input logic lc, input logic [3:0] pp, input bit stall,
                              output int first_valid, output int last_idx, output int last_cyc,
                              output int done_cyc, output int done_after, output int valid_seen,
                              output int unstable, output bit timeout);
      logic [31:0] prev_d;
      logic        prev_v, prev_r, v, l, r;
      bit          done_seen;
      int          cyc;
      got_q.delete();
      last_idx = -1; last_cyc = -1; done_cyc = -1; done_after = -1;
      valid_seen = 0; unstable = 0; done_seen = 0;
      prev_d = '0; prev_v = 1'b0; prev_r = 1'b0;
      @(posedge clk); #1;
      p = pp; t_in_LC = lc; start = 1'b1; sif.dout_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      first_valid = sif.dout_valid;
      cyc = 0;
      while (!done_seen && cyc < 4000) begin
         v = sif.dout_valid;
         l = sif.dout_last;
         if (v) valid_seen++;
         if (prev_v && !prev_r && sif.dout !== prev_d) unstable++;
         if (done) begin
            done_seen = 1;
            done_cyc  = cyc;
         end else begin
            r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            sif.dout_ready = r;
            if (v && r) begin
               got_q.push_back(sif.dout);
               if (l) begin
                  last_idx = got_q.size() - 1;
                  last_cyc = cyc;
               end
            end
            prev_d = sif.dout; prev_v = v; prev_r = r;
            @(posedge clk); #1;
            cyc++;
         end
      end
      timeout = !done_seen;
      if (done_seen) begin
         @(posedge clk); #1;
         done_after = done;
      end
      sif.dout_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; t_in_LC = 1'b0; p = '0; sif.dout_ready = 1'b0;
      fill_random();
      #12;
      n_cmp++; if (sif.dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", sif.dout_valid); end
      n_cmp++; if (sif.dout !== 32'h0) begin n_bad++; $display("FAIL rst_dout got %h want 0", sif.dout); end
      n_cmp++; if (sif.dout_last !== 1'b0) begin n_bad++; $display("FAIL rst_last got %b want 0", sif.dout_last); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
      #5 reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0 || sif.dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_idle busy %b valid %b want 0 0", busy, sif.dout_valid); end
   endtask

   task automatic test_p0();
      int fv, li, lc, dc, da, vs, un, idx;
      bit to;
      logic [31:0] e, s0, c0;
      fill_random();
      s0 = seeds[159:128];
      c0 = C[31:0];
      push_expected(0);
      drive_round(1'b1, 4'd0, 0, fv, li, lc, dc, da, vs, un, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL p0_timeout got timeout want done"); end
      n_cmp++; if (fv !== 1) begin n_bad++; $display("FAIL p0_first_valid got %0d want 1", fv); end
      n_cmp++; if (got_q.size() != 120) begin n_bad++; $display("FAIL p0_len got %0d want 120", got_q.size()); end
      n_cmp++; if (li != 119) begin n_bad++; $display("FAIL p0_last_idx got %0d want 119", li); end
      n_cmp++; if (dc - lc != 1) begin n_bad++; $display("FAIL p0_done_lat got %0d want 1", dc - lc); end
      n_cmp++; if (da !== 0) begin n_bad++; $display("FAIL p0_done_pulse got %0d want 0", da); end
      n_cmp++; if (got_q.size() > 60 && (got_q[0] !== s0 || got_q[60] !== c0)) begin
         n_bad++; $display("FAIL p0_spot got %h/%h want %h/%h", got_q[0], got_q[60], s0, c0);
      end
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (idx < got_q.size()) begin
            n_cmp++;
            if (got_q[idx] !== e) begin n_bad++; $display("FAIL p0_word[%0d] got %h want %h", idx, got_q[idx], e); end
         end
         idx++;
      end
   endtask

   task automatic test_p15();
      int fv, li, lc, dc, da, vs, un, idx;
      bit to;
      logic [31:0] e, s59, k0;
      fill_random();
      s59 = seeds[1919:1888];
      k0  = masked_key[31:0];
      push_expected(15);
      drive_round(1'b1, 4'd15, 0, fv, li, lc, dc, da, vs, un, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL p15_timeout got timeout want done"); end
      n_cmp++; if (got_q.size() != 88) begin n_bad++; $display("FAIL p15_len got %0d want 88", got_q.size()); end
      n_cmp++; if (li != 87) begin n_bad++; $display("FAIL p15_last_idx got %0d want 87", li); end
      n_cmp++; if (got_q.size() > 68 && (got_q[59] !== s59 || got_q[68] !== k0)) begin
         n_bad++; $display("FAIL p15_spot got %h/%h want %h/%h", got_q[59], got_q[68], s59, k0);
      end
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (idx < got_q.size()) begin
            n_cmp++;
            if (got_q[idx] !== e) begin n_bad++; $display("FAIL p15_word[%0d] got %h want %h", idx, got_q[idx], e); end
         end
         idx++;
      end
   endtask

   task automatic test_p7_skip();
      int fv, li, lc, dc, da, vs, un, idx, hits;
      bit to;
      logic [31:0] e;
      fill_random();
      for (int j = 0; j < 64; j++) seeds[j*32 +: 32] = j;
      push_expected(7);
      drive_round(1'b1, 4'd7, 0, fv, li, lc, dc, da, vs, un, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL p7_timeout got timeout want done"); end
      n_cmp++; if (got_q.size() != 120) begin n_bad++; $display("FAIL p7_len got %0d want 120", got_q.size()); end
      n_cmp++; if (got_q.size() > 28 && got_q[28] !== 32'd32) begin n_bad++; $display("FAIL p7_word28 got %h want 00000020", got_q[28]); end
      hits = 0;
      for (int i = 0; i < 60 && i < got_q.size(); i++)
         if (got_q[i] >= 32'd28 && got_q[i] <= 32'd31) hits++;
      n_cmp++; if (hits != 0) begin n_bad++; $display("FAIL p7_party7_present got %0d want 0", hits); end
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (idx < got_q.size()) begin
            n_cmp++;
            if (got_q[idx] !== e) begin n_bad++; $display("FAIL p7_word[%0d] got %h want %h", idx, got_q[idx], e); end
         end
         idx++;
      end
   endtask

   task automatic test_not_lc();
      int fv, li, lc, dc, da, vs, un;
      bit to;
      drive_round(1'b0, 4'd5, 0, fv, li, lc, dc, da, vs, un, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL nolc_timeout got timeout want done"); end
      n_cmp++; if (vs != 0 || fv != 0) begin n_bad++; $display("FAIL nolc_valid got %0d want 0", vs + fv); end
      n_cmp++; if (dc != 0) begin n_bad++; $display("FAIL nolc_done_lat got %0d want 0", dc); end
      n_cmp++; if (da !== 0) begin n_bad++; $display("FAIL nolc_done_pulse got %0d want 0", da); end
   endtask

   task automatic test_stall();
      int fv, li, lc, dc, da, vs, un, idx;
      bit to;
      logic [31:0] e;
      fill_random();
      push_expected(3);
      drive_round(1'b1, 4'd3, 0, fv, li, lc, dc, da, vs, un, to);
      ref_q = got_q;
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (idx >= ref_q.size() || ref_q[idx] !== e) begin
            n_bad++; $display("FAIL p3_word[%0d] got %h want %h", idx, (idx < ref_q.size()) ? ref_q[idx] : 32'hx, e);
         end
         idx++;
      end
      drive_round(1'b1, 4'd3, 1, fv, li, lc, dc, da, vs, un, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL stall_timeout got timeout want done"); end
      n_cmp++; if (got_q.size() != ref_q.size()) begin n_bad++; $display("FAIL stall_len got %0d want %0d", got_q.size(), ref_q.size()); end
      n_cmp++; if (un != 0) begin n_bad++; $display("FAIL stall_hold got %0d changes want 0", un); end
      n_cmp++; if (li != 119) begin n_bad++; $display("FAIL stall_last_idx got %0d want 119", li); end
      for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== ref_q[i]) begin n_bad++; $display("FAIL stall_word[%0d] got %h want %h", i, got_q[i], ref_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int fv, li, lc, dc, da, vs, un, idx, cnt, cyc;
      bit to;
      logic [31:0] e;
      fill_random();
      @(posedge clk); #1;
      p = 4'd0; t_in_LC = 1'b1; start = 1'b1; sif.dout_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0; cyc = 0;
      while (cnt < 40 && cyc < 200) begin
         if (sif.dout_valid) cnt++;
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++; if (cnt != 40) begin n_bad++; $display("FAIL mid_reach40 got %0d want 40", cnt); end
      reset = 1'b0;
      #1;
      n_cmp++; if (sif.dout_valid !== 1'b0 || sif.dout_last !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b%b want 00", sif.dout_valid, sif.dout_last); end
      n_cmp++; if (sif.dout !== 32'h0) begin n_bad++; $display("FAIL mid_rst_dout got %h want 0", sif.dout); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b%b want 00", busy, done); end
      #2 reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0 || sif.dout_valid !== 1'b0) begin n_bad++; $display("FAIL mid_dropped busy %b valid %b want 0 0", busy, sif.dout_valid); end
      push_expected(15);
      drive_round(1'b1, 4'd15, 0, fv, li, lc, dc, da, vs, un, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL mid_timeout got timeout want done"); end
      n_cmp++; if (got_q.size() != 88) begin n_bad++; $display("FAIL mid_len got %0d want 88", got_q.size()); end
      idx = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (idx < got_q.size()) begin
            n_cmp++;
            if (got_q[idx] !== e) begin n_bad++; $display("FAIL mid_word[%0d] got %h want %h", idx, got_q[idx], e); end
         end
         idx++;
      end
   endtask

   initial begin
      test_reset();
      test_p0();
      test_p15();
      test_p7_skip();
      test_not_lc();
      test_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/round_proof_packer.md
# round_proof_packer

Signer-side counterpart of the verify round function: for one parallel repetition it selects the opened material (all party seeds except the unopened party, the unopened party's commitment, aux, masked key, broadcast messages) and streams it as 32-bit words over a valid/ready interface. Its word stream is exactly the field set `seed_i`, `C_i`, `aux_triangle_i`, `masked_key_i`, `msgs_i` that the verifier unpacks, in the order below. It sits between the signer's per-round MPC/commitment stage and the signature serializer.

## Interface
- `W`, 32: output word width. Only 32 is supported.
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-low.
- `start` input 1: one-cycle request, accepted only in IDLE.
- `t_in_LC` input 1: round is in the challenge list. 0 means nothing is emitted.
- `p` input 4: unopened party index, 0..15.
- `seeds` input 2048: 16 party seeds. Party k occupies `[k*128 +: 128]`.
- `C` input 4096: 16 commitments. Party k occupies `[k*256 +: 256]`.
- `aux_triangle` input 1024: aux bits of the last party.
- `masked_key` input 128: masked key.
- `msgs` input 512: broadcast messages of party p.
- `dout` output 32: stream word.
- `dout_valid` output 1: `dout` holds a valid word.
- `dout_ready` input 1: consumer accepts the word.
- `dout_last` output 1: final word of the round.
- `busy` output 1: FSM is not in IDLE.
- `done` output 1: one-cycle pulse when the round is finished.

## Operation
- Data inputs are not latched. They must stay stable from `start` until `done`. `p` and `t_in_LC` are registered at `start`.
- Field order and word counts, with words taken LSB-first inside each field:
  - SEED: 60 words. Parties 0..15 in ascending order, party p skipped. Word w of party k is `seeds[k*128 + w*32 +: 32]`.
  - COM: 8 words from `C[p*256 +: 256]`.
  - AUX: 32 words. Present only when `p != 15`. When `p == 15` the state is skipped.
  - KEY: 4 words.
  - MSG: 16 words.
- Total length is 120 words when `p != 15` and 88 words when `p == 15`.
- FSM states and transitions:
  - IDLE → SEED on `start` when `t_in_LC = 1`.
  - IDLE → DONE on `start` when `t_in_LC = 0`.
  - SEED → COM → AUX/KEY → MSG → DONE. Each transition fires on the handshake of that field's final word.
  - DONE → IDLE after one cycle. `done` is high during the DONE cycle.
- Counters:
  - `party_cnt` (4 bits) and `word_cnt` (6 bits), both reset to 0 on entry to each field.
  - In SEED, `party_cnt` skips p: after word 3 of party k, it advances to k+1, or k+2 if k+1 == p.
- A handshake occurs when `dout_valid && dout_ready`. `dout` advances only on a handshake.
- `dout_last` is high only with the final MSG word.
- `start` is ignored while `busy`.

## Timing
- Reset values: `dout = 0`, `dout_valid = 0`, `dout_last = 0`, `busy = 0`, `done = 0`, FSM in IDLE, counters 0.
- `dout` and `dout_valid` are registered.
- The first word is valid in the cycle after `start` is sampled.
- Throughput is 1 word/cycle while `dout_ready = 1`.
- `done` is asserted one cycle after the `dout_last` handshake.
- A non-LC round asserts `done` one cycle after `start`, with no words emitted.
- Backpressure: while `dout_valid && !dout_ready`, `dout`, `dout_last` and all counters hold.
- `dout_ready` may toggle arbitrarily. No combinational path exists from `dout_ready` to `dout_valid`.
- Asynchronous reset mid-stream returns the FSM to IDLE immediately and drops the rest of the round.

## Structure
- Shared package `picnic_pkg` holds:
  - `N_PARTY = 16`.
  - Field word counts `SEED_WORDS = 60`, `COM_WORDS = 8`, `AUX_WORDS = 32`, `KEY_WORDS = 4`, `MSG_WORDS = 16`.
  - FSM state enum `proof_field_t`.
- One sub-module, `round_proof_word_mux`: combinational. Takes state, `party_cnt`, `word_cnt`, `p` and the data buses; returns the next 32-bit word. The top level holds the FSM, counters and output registers.

## Test plan
- **p = 0, ready held high.** Expect 120 consecutive words. Word 0 = `seeds[159:128]`. Words 60..67 = `C[255:0]`. `dout_last` on word 119. `done` one cycle later.
- **p = 15.** Expect 88 words and no AUX. Word 59 = `seeds[1919:1888]`. Word 68 = `masked_key[31:0]`.
- **p = 7, seeds loaded with word index pattern.** Party 7 is absent from the SEED field. Word 28 = first word of party 8.
- **t_in_LC = 0.** `dout_valid` never rises. `done` pulses exactly one cycle after `start`.
- **p = 3, `dout_ready` toggled by random 50% stall.** Word sequence is identical to the no-stall run. `dout` is stable during every stall.
- **Reset asserted at word 40, then new start with p = 15.** Outputs go to reset values immediately. The new stream starts from word 0 and is 88 words long.
